// File: rtl/polaris_pkg.sv
// polaris_pkg: opcodes, instruction class codes and the bubble word shared by the decode stage.
// No ports. decode_class maps a 7-bit major opcode to its class code. The
// 32-bit word opcodes are only recognised when rv64 is set.
package polaris_pkg;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // ADDI x0,x0,0
    localparam logic [31:0] BUBBLE_INSN = 32'h00000013;

    typedef enum logic [3:0] {
        CLS_OP_IMM    = 4'd0,
        CLS_OP        = 4'd1,
        CLS_LUI       = 4'd2,
        CLS_AUIPC     = 4'd3,
        CLS_JAL       = 4'd4,
        CLS_JALR      = 4'd5,
        CLS_BRANCH    = 4'd6,
        CLS_LOAD      = 4'd7,
        CLS_STORE     = 4'd8,
        CLS_OP_IMM_32 = 4'd9,
        CLS_OP_32     = 4'd10,
        CLS_ILLEGAL   = 4'd15
    } cls_e;

    function automatic cls_e decode_class(input logic [6:0] opc, input logic rv64);
        return opc == OPC_OP_IMM            ? CLS_OP_IMM    :
               opc == OPC_OP                ? CLS_OP        :
               opc == OPC_LUI               ? CLS_LUI       :
               opc == OPC_AUIPC             ? CLS_AUIPC     :
               opc == OPC_JAL               ? CLS_JAL       :
               opc == OPC_JALR              ? CLS_JALR      :
               opc == OPC_BRANCH            ? CLS_BRANCH    :
               opc == OPC_LOAD              ? CLS_LOAD      :
               opc == OPC_STORE             ? CLS_STORE     :
               rv64 && opc == OPC_OP_IMM_32 ? CLS_OP_IMM_32 :
               rv64 && opc == OPC_OP_32     ? CLS_OP_32     :
                                              CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/stage_d_p_imm_gen.sv
// imm_gen: extracts the I/S/B/U/J immediate of an instruction and sign-extends it to XLEN.
// Ports: ir_i (instruction word), cls_i (decoded class), imm_o (XLEN-bit immediate;
// zero for register-register and illegal classes).
module imm_gen
    import polaris_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     ir_i,
    input  cls_e            cls_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, imm32;

    assign i_imm = {{20{ir_i[31]}}, ir_i[31:20]};
    assign s_imm = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
    assign b_imm = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
    assign u_imm = {ir_i[31:12], 12'b0};
    assign j_imm = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};

    assign imm32 = (cls_i inside {CLS_OP_IMM, CLS_OP_IMM_32, CLS_JALR, CLS_LOAD}) ? i_imm :
                   cls_i == CLS_STORE                                          ? s_imm :
                   cls_i == CLS_BRANCH                                         ? b_imm :
                   (cls_i inside {CLS_LUI, CLS_AUIPC})                         ? u_imm :
                   cls_i == CLS_JAL                                            ? j_imm :
                                                                                 32'd0;

    // Every format already carries IR[31] in bit 31, so a signed widen finishes the job.
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/stage_d_p.sv
// stage_d_p: decode stage holding the instruction register and PC and decoding them combinationally.
// Ports: clk_i/reset_ni (clock, async active-low reset); f_ack_i/f_dat_i/f_pc_i (fetch word);
// d_rdy_o (fetch word accepted); e_rdy_i (execute accepts); r_dat1_i/r_dat2_i (register-file
// read data); d_* outputs (decoded fields, operands, class and illegal flag of the held IR).
module stage_d_p
    import polaris_pkg::*;
#(
    parameter int          XLEN   = 64,
    parameter logic [31:0] BUBBLE = BUBBLE_INSN
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            f_ack_i,
    input  logic [31:0]     f_dat_i,
    input  logic [XLEN-1:0] f_pc_i,
    output logic            d_rdy_o,
    input  logic            e_rdy_i,
    output logic            d_valid_o,
    output logic [4:0]      d_rs1_o,
    output logic [4:0]      d_rs2_o,
    input  logic [XLEN-1:0] r_dat1_i,
    input  logic [XLEN-1:0] r_dat2_i,
    output logic [4:0]      d_rd_o,
    output logic [XLEN-1:0] d_vs1_o,
    output logic [XLEN-1:0] d_vs2_o,
    output logic [XLEN-1:0] d_imm_o,
    output logic [XLEN-1:0] d_sdat_o,
    output logic [3:0]      d_class_o,
    output logic [2:0]      d_fn3_o,
    output logic            d_alt_o,
    output logic            d_w32_o,
    output logic            d_illegal_o
);

    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    cls_e            cls;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_dat, rs2_dat, imm;
    logic            shift_imm;

    assign d_rdy_o = e_rdy_i;

    assign ir_d    = e_rdy_i ? (f_ack_i ? f_dat_i : BUBBLE) : ir_q;
    assign pc_d    = e_rdy_i ? f_pc_i : pc_q;
    assign valid_d = e_rdy_i ? f_ack_i : valid_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ir_q    <= BUBBLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign cls = decode_class(ir_q[6:0], XLEN == 64);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .ir_i  (ir_q),
        .cls_i (cls),
        .imm_o (imm)
    );

    // Classes without a source operand (and ILLEGAL) report address 0.
    assign rs1 = (cls inside {CLS_OP_IMM, CLS_OP, CLS_JALR, CLS_BRANCH, CLS_LOAD,
                              CLS_STORE, CLS_OP_IMM_32, CLS_OP_32}) ? ir_q[19:15] : 5'd0;
    assign rs2 = (cls inside {CLS_OP, CLS_BRANCH, CLS_STORE, CLS_OP_32}) ? ir_q[24:20] : 5'd0;

    // x0 always reads as zero, whatever the register file returns.
    assign rs1_dat = rs1 == 5'd0 ? '0 : r_dat1_i;
    assign rs2_dat = rs2 == 5'd0 ? '0 : r_dat2_i;

    // SLLI/SRLI/SRAI (fn3 001/101) carry the arithmetic-shift select in IR[30].
    assign shift_imm = (cls inside {CLS_OP_IMM, CLS_OP_IMM_32}) && ir_q[13:12] == 2'b01;

    assign d_valid_o   = valid_q;
    assign d_rs1_o     = rs1;
    assign d_rs2_o     = rs2;
    assign d_rd_o      = (cls inside {CLS_BRANCH, CLS_STORE, CLS_ILLEGAL}) ? 5'd0 : ir_q[11:7];
    assign d_imm_o     = imm;
    assign d_vs1_o     = cls == CLS_LUI                         ? '0   :
                         (cls inside {CLS_AUIPC, CLS_JAL})      ? pc_q : rs1_dat;
    assign d_vs2_o     = (cls inside {CLS_OP, CLS_OP_32, CLS_BRANCH}) ? rs2_dat : imm;
    assign d_sdat_o    = cls == CLS_STORE ? rs2_dat : '0;
    assign d_class_o   = cls;
    assign d_fn3_o     = ir_q[14:12];
    assign d_alt_o     = ((cls inside {CLS_OP, CLS_OP_32}) || shift_imm) && ir_q[30];
    assign d_w32_o     = cls inside {CLS_OP_IMM_32, CLS_OP_32};
    // A bubble never raises illegal, even if BUBBLE is overridden with an odd word.
    assign d_illegal_o = cls == CLS_ILLEGAL && valid_q;

endmodule

// File: tb/tb_stage_d_p.sv
// tb_stage_d_p: scoreboard bench for stage_d_p (XLEN=64 instance plus an XLEN=32 instance).
module tb_stage_d_p;

    typedef struct packed {
        logic        v;
        logic [3:0]  c;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt, w32, ill;
        logic [63:0] imm, vs1, vs2, sd;
    } dec_t;

    logic        clk_i = 1'b0, reset_ni = 1'b0, f_ack_i = 1'b0, e_rdy_i = 1'b0;
    logic [31:0] f_dat_i = '0;
    logic [63:0] f_pc_i = '0, r_dat1_i = '0, r_dat2_i = '0;

    logic        d_rdy_o, d_valid_o, d_alt_o, d_w32_o, d_illegal_o;
    logic [4:0]  d_rs1_o, d_rs2_o, d_rd_o;
    logic [63:0] d_vs1_o, d_vs2_o, d_imm_o, d_sdat_o;
    logic [3:0]  d_class_o;
    logic [2:0]  d_fn3_o;

    logic        n_rdy, n_valid, n_alt, n_w32, n_ill;
    logic [4:0]  n_rs1, n_rs2, n_rd;
    logic [31:0] n_vs1, n_vs2, n_imm, n_sdat;
    logic [3:0]  n_class;
    logic [2:0]  n_fn3;

    int   checks = 0, errors = 0;
    dec_t sb[$];

    localparam dec_t BUB = '0;

    stage_d_p #(.XLEN(64)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .f_ack_i(f_ack_i), .f_dat_i(f_dat_i), .f_pc_i(f_pc_i),
        .d_rdy_o(d_rdy_o), .e_rdy_i(e_rdy_i), .d_valid_o(d_valid_o), .d_rs1_o(d_rs1_o),
        .d_rs2_o(d_rs2_o), .r_dat1_i(r_dat1_i), .r_dat2_i(r_dat2_i), .d_rd_o(d_rd_o),
        .d_vs1_o(d_vs1_o), .d_vs2_o(d_vs2_o), .d_imm_o(d_imm_o), .d_sdat_o(d_sdat_o),
        .d_class_o(d_class_o), .d_fn3_o(d_fn3_o), .d_alt_o(d_alt_o), .d_w32_o(d_w32_o),
        .d_illegal_o(d_illegal_o)
    );

    stage_d_p #(.XLEN(32)) dut32 (
        .clk_i(clk_i), .reset_ni(reset_ni), .f_ack_i(f_ack_i), .f_dat_i(f_dat_i), .f_pc_i(f_pc_i[31:0]),
        .d_rdy_o(n_rdy), .e_rdy_i(e_rdy_i), .d_valid_o(n_valid), .d_rs1_o(n_rs1),
        .d_rs2_o(n_rs2), .r_dat1_i(r_dat1_i[31:0]), .r_dat2_i(r_dat2_i[31:0]), .d_rd_o(n_rd),
        .d_vs1_o(n_vs1), .d_vs2_o(n_vs2), .d_imm_o(n_imm), .d_sdat_o(n_sdat),
        .d_class_o(n_class), .d_fn3_o(n_fn3), .d_alt_o(n_alt), .d_w32_o(n_w32),
        .d_illegal_o(n_ill)
    );

    always #5 clk_i = ~clk_i;

    function automatic dec_t got();
        return {d_valid_o, d_class_o, d_rd_o, d_rs1_o, d_rs2_o, d_fn3_o, d_alt_o, d_w32_o,
                d_illegal_o, d_imm_o, d_vs1_o, d_vs2_o, d_sdat_o};
    endfunction

    function automatic dec_t mk(logic v, logic [3:0] c, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [2:0] f3, logic alt, logic w32, logic ill,
                                logic [63:0] imm, logic [63:0] vs1, logic [63:0] vs2, logic [63:0] sd);
        return {v, c, rd, rs1, rs2, f3, alt, w32, ill, imm, vs1, vs2, sd};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one fetch word with execute ready, record what decode must show next cycle.
    task automatic issue(input logic ack, input logic [31:0] insn, input logic [63:0] pc, input dec_t e);
        f_ack_i = ack;
        f_dat_i = insn;
        f_pc_i  = pc;
        e_rdy_i = 1'b1;
        sb.push_back(e);
        tick();
    endtask

    task automatic test_reset();
        dec_t g;
        reset_ni = 1'b0;
        f_ack_i  = 1'b1;
        f_dat_i  = 32'hFFFFFFFF;
        e_rdy_i  = 1'b1;
        r_dat1_i = '1;
        r_dat2_i = '1;
        tick();
        tick();
        g = got();
        checks++;
        if (g !== BUB) begin
            errors++;
            $display("FAIL reset_decode got %h exp %h", g, BUB);
        end
        checks++;
        if (d_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy got %b exp 1", d_rdy_o);
        end
    endtask

    task automatic test_bubble();
        dec_t g, e;
        reset_ni = 1'b1;
        issue(1'b0, 32'hFFFFFFFF, 64'h40, BUB);
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL bubble_decode got %h exp %h", g, e);
        end
        checks++;
        if (d_vs2_o !== 64'd0) begin
            errors++;
            $display("FAIL bubble_vs2 got %h exp 0", d_vs2_o);
        end
    endtask

    task automatic test_addi();
        dec_t g, e;
        r_dat1_i = 64'd10;
        r_dat2_i = 64'd77;
        issue(1'b1, 32'hFFF08293, 64'h100,
              mk(1, 0, 5, 1, 0, 3'b000, 0, 0, 0, '1, 64'd10, '1, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL addi got %h exp %h", g, e);
        end
        checks++;
        if (n_imm !== 32'hFFFFFFFF || n_vs1 !== 32'd10 || n_class !== 4'd0) begin
            errors++;
            $display("FAIL addi_rv32 got imm %h vs1 %h cls %0d exp ffffffff 0000000a 0", n_imm, n_vs1, n_class);
        end
    endtask

    task automatic test_lui();
        dec_t g, e;
        issue(1'b1, 32'h123451B7, 64'h104,
              mk(1, 2, 3, 0, 0, 3'b101, 0, 0, 0, 64'h12345000, 0, 64'h12345000, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL lui got %h exp %h", g, e);
        end
    endtask

    task automatic test_store_stall();
        dec_t g, e;
        r_dat2_i = 64'd55;
        issue(1'b1, 32'h0020A423, 64'h108,
              mk(1, 8, 0, 1, 2, 3'b010, 0, 0, 0, 64'd8, 64'd10, 64'd8, 64'd55));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL store got %h exp %h", g, e);
        end
        e_rdy_i = 1'b0;
        f_ack_i = 1'b1;
        f_dat_i = 32'hFFF08293;
        f_pc_i  = 64'h900;
        for (int i = 0; i < 3; i++) begin
            tick();
            g = got();
            checks++;
            if (g !== e || d_rdy_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got %h rdy %b exp %h rdy 0", i, g, d_rdy_o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        dec_t g, e;
        // beq x1,x2,-4 ; jal x1,+8 ; auipc x2,0x80000 ; srai x5,x1,3
        issue(1'b1, 32'hFE208EE3, 64'h2000,
              mk(1, 6, 0, 1, 2, 3'b000, 0, 0, 0, 64'hFFFFFFFFFFFFFFFC, 64'd10, 64'd55, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL branch got %h exp %h", g, e);
        end
        issue(1'b1, 32'h008000EF, 64'h1000,
              mk(1, 4, 1, 0, 0, 3'b000, 0, 0, 0, 64'd8, 64'h1000, 64'd8, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL jal got %h exp %h", g, e);
        end
        issue(1'b1, 32'h80000117, 64'h3000,
              mk(1, 3, 2, 0, 0, 3'b000, 0, 0, 0, 64'hFFFFFFFF80000000, 64'h3000, 64'hFFFFFFFF80000000, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL auipc got %h exp %h", g, e);
        end
        issue(1'b1, 32'h4030D293, 64'h3004,
              mk(1, 0, 5, 1, 0, 3'b101, 1, 0, 0, 64'h403, 64'd10, 64'h403, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL srai got %h exp %h", g, e);
        end
    endtask

    task automatic test_word_ops();
        dec_t g, e;
        // addw x3,x1,x2 then subw x3,x1,x2
        issue(1'b1, 32'h002081BB, 64'h3008,
              mk(1, 10, 3, 1, 2, 3'b000, 0, 1, 0, 0, 64'd10, 64'd55, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL addw got %h exp %h", g, e);
        end
        checks++;
        if ({n_class, n_ill, n_rd, n_rs1, n_rs2} !== {4'd15, 1'b1, 15'd0}) begin
            errors++;
            $display("FAIL addw_rv32 got cls %0d ill %b rd %0d rs1 %0d rs2 %0d exp 15 1 0 0 0",
                     n_class, n_ill, n_rd, n_rs1, n_rs2);
        end
        issue(1'b1, 32'h402081BB, 64'h300C,
              mk(1, 10, 3, 1, 2, 3'b000, 1, 1, 0, 0, 64'd10, 64'd55, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL subw got %h exp %h", g, e);
        end
    endtask

    task automatic test_illegal();
        dec_t g, e;
        issue(1'b1, 32'hFFFFFFFF, 64'h3010,
              mk(1, 15, 0, 0, 0, 3'b111, 0, 0, 1, 0, 0, 0, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL illegal got %h exp %h", g, e);
        end
    endtask

    task automatic test_reset_mid_stall();
        dec_t g, e;
        issue(1'b1, 32'hFFF08293, 64'h500,
              mk(1, 0, 5, 1, 0, 3'b000, 0, 0, 0, '1, 64'd10, '1, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL pre_reset_addi got %h exp %h", g, e);
        end
        e_rdy_i = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        g = got();
        checks++;
        if (g !== BUB) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", g, BUB);
        end
        tick();
        reset_ni = 1'b1;
        issue(1'b1, 32'h123451B7, 64'h600,
              mk(1, 2, 3, 0, 0, 3'b101, 0, 0, 0, 64'h12345000, 0, 64'h12345000, 0));
        e = sb.pop_front();
        g = got();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL post_reset_lui got %h exp %h", g, e);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_bubble();
        test_addi();
        test_lui();
        test_store_stall();
        test_back_to_back();
        test_word_ops();
        test_illegal();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
